// File: rtl/fb_pixel_writer_if.sv
// Pixel request handshake plus framebuffer write bus for fb_pixel_writer.
// master = drawing side / observer, slave = the writer itself.
interface fb_pixel_writer_if;
    logic        px_valid;
    logic        px_ready;
    logic [8:0]  px_x;
    logic [7:0]  px_y;
    logic [2:0]  px_color;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;

    modport master (
        output px_valid, px_x, px_y, px_color,
        input  px_ready, fb_we, fb_addr, fb_data
    );

    modport slave (
        input  px_valid, px_x, px_y, px_color,
        output px_ready, fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// Write-side front end for the 320x240x3b framebuffer: FIFO-buffered pixel
// writes, x/y to linear address conversion, and a full-frame clear sweep.
module fb_pixel_writer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int CLEAR_ON_FRAME = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 new_frame,
    fb_pixel_writer_if.slave     bus,
    output logic                 clearing,
    output logic [7:0]           drop_count
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [16:0] LAST_ADDR = 17'd76799;
    localparam logic [0:0]  ST_WRITE  = 1'b0;
    localparam logic [0:0]  ST_CLEAR  = 1'b1;

    // ok is resolved at acceptance so the drop counter and the pop path agree
    typedef struct packed {
        logic       ok;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] color;
    } px_req_t;

    px_req_t     mem [FIFO_DEPTH];
    px_req_t     in_req;
    px_req_t     head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop, restart;
    logic [0:0]  state;
    logic [16:0] clr_cnt, clr_addr, head_addr;

    logic        s1_vld;
    logic [16:0] s1_addr;
    logic [2:0]  s1_color;

    logic        fb_we_q;
    logic [16:0] fb_addr_q;
    logic [2:0]  fb_data_q;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // ready is held low during reset and never depends on px_valid
    assign bus.px_ready = rst_n & ~full;
    assign push         = bus.px_valid & bus.px_ready;

    assign restart = (CLEAR_ON_FRAME != 0) && new_frame;
    // entering a clear wins over a pending pop; the entry stays queued
    assign pop     = (state == ST_WRITE) && !empty && !restart;

    always_comb begin
        in_req.ok    = (bus.px_x <= 9'd319) && (bus.px_y <= 8'd239);
        in_req.x     = bus.px_x;
        in_req.y     = bus.px_y;
        in_req.color = bus.px_color;
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    // y*320 + x without a multiplier
    assign head_addr = ({9'd0, head.y} << 8) + ({9'd0, head.y} << 6) + {8'd0, head.x};
    assign clr_addr  = restart ? 17'd0 : clr_cnt;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= '0;
            state      <= ST_WRITE;
            clr_cnt    <= '0;
            s1_vld     <= 1'b0;
            s1_addr    <= '0;
            s1_color   <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            clearing   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (push && !in_req.ok && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;

            // stage 1: pop and address conversion
            s1_vld <= pop && head.ok;
            if (pop) begin
                s1_addr  <= head_addr;
                s1_color <= head.color;
            end

            // stage 2: registered framebuffer port, shared with the sweep
            case (state)
                ST_WRITE: begin
                    fb_we_q  <= s1_vld;
                    clearing <= 1'b0;
                    if (s1_vld) begin
                        fb_addr_q <= s1_addr;
                        fb_data_q <= s1_color;
                    end
                    if (restart) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    fb_we_q   <= 1'b1;
                    fb_addr_q <= clr_addr;
                    fb_data_q <= 3'd0;
                    clearing  <= 1'b1;
                    clr_cnt   <= clr_addr + 17'd1;
                    if (clr_addr == LAST_ADDR) state <= ST_WRITE;
                end
                default: state <= ST_WRITE;
            endcase
        end
    end

    assign bus.fb_we   = fb_we_q;
    assign bus.fb_addr = fb_addr_q;
    assign bus.fb_data = fb_data_q;
endmodule
